// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2 DRP reconfiguration controller:
// FSM states, clock-register addresses, error codes and the divider encoder.
package pll_drp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ON,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_HOLD,
    ST_LOCK_WAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [6:0] ADDR_CLKOUT0_REG1 = 7'h08;
  localparam logic [6:0] ADDR_CLKOUT0_REG2 = 7'h09;
  localparam logic [6:0] ADDR_CLKOUT1_REG1 = 7'h0A;
  localparam logic [6:0] ADDR_CLKOUT1_REG2 = 7'h0B;
  localparam logic [6:0] ADDR_CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] ADDR_CLKFBOUT_REG2 = 7'h15;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_BAD_ARG      = 2'd1;
  localparam logic [1:0] ERR_DRP_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_LOCK_TIMEOUT = 2'd3;

  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef struct packed {
    logic [5:0] high;
    logic [5:0] low;
    logic       edge_bit;
    logic       nocount;
  } div_enc_t;

  // Divide-by-1 bypasses the counter entirely, so high/low are forced to 1
  // and the half-cycle edge bit is left clear.
  function automatic div_enc_t pll_div_encode(input logic [6:0] d);
    div_enc_t   e;
    logic [6:0] h;
    logic [6:0] l;
    h = d >> 1;
    l = d - h;
    e.high     = h[5:0];
    e.low      = l[5:0];
    e.edge_bit = d[0];
    e.nocount  = 1'b0;
    if (d == 7'd1) begin
      e.high     = 6'd1;
      e.low      = 6'd1;
      e.edge_bit = 1'b0;
      e.nocount  = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [6:0] entry_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return ADDR_CLKOUT0_REG1;
      3'd1:    return ADDR_CLKOUT0_REG2;
      3'd2:    return ADDR_CLKOUT1_REG1;
      3'd3:    return ADDR_CLKOUT1_REG2;
      3'd4:    return ADDR_CLKFBOUT_REG1;
      default: return ADDR_CLKFBOUT_REG2;
    endcase
  endfunction

  function automatic logic arg_valid(input logic [6:0] v);
    return (v != 7'd0) && (v != 7'h7F);
  endfunction

endpackage

// File: rtl/pll_drp_merge.sv
// Read-modify-write merge: folds an encoded divider into the word read back
// from a PLL clock register (Reg1 = high/low counts, Reg2 = edge/nocount).
module pll_drp_merge
  import pll_drp_pkg::*;
(
  input  logic [15:0] old_word_i,
  input  logic [5:0]  high_i,
  input  logic [5:0]  low_i,
  input  logic        edge_i,
  input  logic        nocount_i,
  input  logic        sel_reg2_i,
  output logic [15:0] new_word_o
);

  // NOTE: assign a default before any branch so combinational logic never infers a latch.
  always_comb begin
    new_word_o = old_word_i;
    if (sel_reg2_i) begin
      new_word_o[7] = edge_i;
      new_word_o[6] = nocount_i;
    end else begin
      new_word_o[11:0] = {high_i, low_i};
    end
  end

endmodule

// File: rtl/pll_drp_ctrl.sv
// PLLE2 runtime reconfiguration: holds the PLL in reset, rewrites the six
// clock registers over DRP by read-modify-write, then releases and awaits lock.
module pll_drp_ctrl
  import pll_drp_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned DRP_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_req_i,
  input  logic [6:0]  cfg_mult_i,
  input  logic [6:0]  cfg_div0_i,
  input  logic [6:0]  cfg_div1_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic [1:0]  cfg_err_code_o,
  output logic [6:0]  drp_addr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  input  logic        drp_rdy_i,
  output logic        pll_rst_o,
  input  logic        pll_locked_i,
  output logic        locked_o
);

  localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] DRP_LAST  = 16'(DRP_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  mult_q, mult_d, div0_q, div0_d, div1_q, div1_d;
  logic        arg_ok_q, arg_ok_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] di_q, di_d;
  logic [1:0]  code_q, code_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        den_q, den_d, dwe_q, dwe_d, pll_rst_q, pll_rst_d;
  logic        sync1_q, sync2_q;
  logic [6:0]  cur_div;
  div_enc_t    enc;
  logic [15:0] merged;

  always_comb begin
    case (idx_q[2:1])
      2'd0:    cur_div = div0_q;
      2'd1:    cur_div = div1_q;
      default: cur_div = mult_q;
    endcase
    enc = pll_div_encode(cur_div);
  end

  pll_drp_merge u_merge (
    .old_word_i (drp_do_i),
    .high_i     (enc.high),
    .low_i      (enc.low),
    .edge_i     (enc.edge_bit),
    .nocount_i  (enc.nocount),
    .sel_reg2_i (idx_q[0]),
    .new_word_o (merged)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mult_d   = mult_q;
    div0_d   = div0_q;
    div1_d   = div1_q;
    arg_ok_d = arg_ok_q;
    addr_d   = addr_q;
    di_d     = di_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE: if (cfg_req_i) begin
        mult_d   = cfg_mult_i;
        div0_d   = cfg_div0_i;
        div1_d   = cfg_div1_i;
        arg_ok_d = arg_valid(cfg_mult_i) && arg_valid(cfg_div0_i) && arg_valid(cfg_div1_i);
        idx_d    = 3'd0;
        code_d   = ERR_NONE;
        state_d  = ST_RST_ON;
      end
      // Bad arguments are rejected here so the PLL reset is never raised for them.
      ST_RST_ON: if (!arg_ok_q) begin
        code_d  = ERR_BAD_ARG;
        state_d = ST_ERR;
      end else begin
        addr_d  = entry_addr(idx_q);
        state_d = ST_RD;
      end
      ST_RD: state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (drp_rdy_i) begin
        di_d    = merged;
        state_d = ST_WR;
      end else if (wait_q == DRP_LAST) begin
        code_d  = ERR_DRP_TIMEOUT;
        state_d = ST_ERR;
      end
      ST_WR: state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (drp_rdy_i) begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_HOLD;
        end else begin
          idx_d   = idx_q + 3'd1;
          addr_d  = entry_addr(idx_q + 3'd1);
          state_d = ST_RD;
        end
      end else if (wait_q == DRP_LAST) begin
        code_d  = ERR_DRP_TIMEOUT;
        state_d = ST_ERR;
      end
      ST_HOLD: if (wait_q == HOLD_LAST) state_d = ST_LOCK_WAIT;
      ST_LOCK_WAIT: if (sync2_q) begin
        state_d = ST_DONE;
      end else if (wait_q == LOCK_LAST) begin
        code_d  = ERR_LOCK_TIMEOUT;
        state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wait_d = (state_d != state_q || state_q == ST_IDLE) ? 16'd0 : wait_q + 16'd1;

    // Outputs are decoded from the next state and registered, so they are glitch-free.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
    den_d  = (state_d == ST_RD) || (state_d == ST_WR);
    dwe_d  = (state_d == ST_WR);
    case (state_d)
      ST_RST_ON: pll_rst_d = arg_ok_d;
      ST_RD, ST_RD_WAIT, ST_WR, ST_WR_WAIT, ST_HOLD: pll_rst_d = 1'b1;
      default: pll_rst_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      idx_q     <= '0;
      mult_q    <= '0;
      div0_q    <= '0;
      div1_q    <= '0;
      arg_ok_q  <= 1'b0;
      addr_q    <= '0;
      di_q      <= '0;
      code_q    <= ERR_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      pll_rst_q <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      mult_q    <= mult_d;
      div0_q    <= div0_d;
      div1_q    <= div1_d;
      arg_ok_q  <= arg_ok_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      pll_rst_q <= pll_rst_d;
      sync1_q   <= pll_locked_i;
      sync2_q   <= sync1_q;
    end
  end

  assign cfg_busy_o     = busy_q;
  assign cfg_done_o     = done_q;
  assign cfg_err_o      = err_q;
  assign cfg_err_code_o = code_q;
  assign drp_addr_o     = addr_q;
  assign drp_di_o       = di_q;
  assign drp_den_o      = den_q;
  assign drp_dwe_o      = dwe_q;
  assign pll_rst_o      = pll_rst_q;
  assign locked_o       = sync2_q;

endmodule
